// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: registered program counter with sequential advance and
// jump / branch / register-jump / exception redirects, driven out through a
// valid/ready fetch handshake. One non-exception redirect can be held
// pending while the fetch port is stalled or not ready.
//
// Optional build macro DELAY_SLOT_EN: when defined, non-exception redirects
// take effect one accepted fetch late (the delay slot is fetched) and do
// not raise flush. Exceptions behave the same in both builds.
module pc_redirect_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        IDX_W    = 26,
  parameter int unsigned        ALIGN    = 2,
  parameter int unsigned        OFF_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready,
  input  logic              stall,
  input  logic [ADDR_W-1:0] ctl_pc,
  input  logic              jump_en,
  input  logic [IDX_W-1:0]  jump_index,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              jr_en,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              exc_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              flush,
  output logic              addr_err
);

  // Sequential step, low alignment bits, and the PC bits kept by a J-type jump.
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(1) << ALIGN;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] HI_MASK    = ~((ADDR_W'(1) << (IDX_W + ALIGN)) - ADDR_W'(1));

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              addr_err_q, addr_err_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
`ifdef DELAY_SLOT_EN
  logic              pend_wait_q, pend_wait_d;
`endif

  // Combinational request decode
  logic              accept_s;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] ctl4_s;
  logic [ADDR_W-1:0] boff_ext_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic [ADDR_W-1:0] branch_tgt_s;
  logic              jr_mis_s;
  logic              exc_s;
  logic              redir_s;
  logic [ADDR_W-1:0] redir_tgt_s;

  assign pc_out   = pc_q;
  assign pc_valid = valid_q;
  assign flush    = flush_q;
  assign addr_err = addr_err_q;

  // Target arithmetic and priority selection of the winning redirect.
  always_comb begin
    accept_s     = valid_q & fetch_ready & ~stall;
    seq_s        = pc_q + STEP;
    ctl4_s       = ctl_pc + STEP;
    boff_ext_s   = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    jump_tgt_s   = (ctl4_s & HI_MASK) | (ADDR_W'(jump_index) << ALIGN);
    branch_tgt_s = ctl4_s + (boff_ext_s << ALIGN);
    // A misaligned jr only matters when jr is the winning request.
    jr_mis_s     = ~exc_en & jr_en & ((jr_addr & ALIGN_MASK) != {ADDR_W{1'b0}});
    exc_s        = exc_en | jr_mis_s;
    redir_s      = 1'b0;
    redir_tgt_s  = {ADDR_W{1'b0}};
    if (jr_en) begin
      redir_s     = 1'b1;
      redir_tgt_s = jr_addr;
    end else if (jump_en) begin
      redir_s     = 1'b1;
      redir_tgt_s = jump_tgt_s;
    end else if (branch_en) begin
      redir_s     = 1'b1;
      redir_tgt_s = branch_tgt_s;
    end else begin
      redir_s     = 1'b0;
      redir_tgt_s = {ADDR_W{1'b0}};
    end
  end

  // Next-state: exception first, then pending, then a fresh redirect, then sequential.
  always_comb begin
    pc_d        = pc_q;
    valid_d     = 1'b1;
    flush_d     = 1'b0;
    addr_err_d  = 1'b0;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
`ifdef DELAY_SLOT_EN
    pend_wait_d = pend_wait_q;
`endif
    if (exc_s) begin
      // Exceptions bypass the handshake and wipe any held redirect.
      pc_d        = EXC_VEC;
      flush_d     = 1'b1;
      addr_err_d  = jr_mis_s;
      pend_d      = 1'b0;
`ifdef DELAY_SLOT_EN
      pend_wait_d = 1'b0;
`endif
    end else if (pend_q) begin
      // New non-exception redirects are wrong-path while one is held.
      if (accept_s) begin
`ifdef DELAY_SLOT_EN
        if (pend_wait_q) begin
          pc_d        = seq_s;
          pend_wait_d = 1'b0;
        end else begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
        end
`else
        pc_d    = pend_tgt_q;
        pend_d  = 1'b0;
        flush_d = 1'b1;
`endif
      end else begin
        pc_d = pc_q;
      end
    end else if (redir_s) begin
`ifdef DELAY_SLOT_EN
      // Always park the target; the delay slot must be fetched first.
      pend_d     = 1'b1;
      pend_tgt_d = redir_tgt_s;
      if (accept_s) begin
        pc_d        = seq_s;
        pend_wait_d = 1'b0;
      end else begin
        pend_wait_d = 1'b1;
      end
`else
      if (accept_s) begin
        pc_d    = redir_tgt_s;
        flush_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_tgt_d = redir_tgt_s;
      end
`endif
    end else if (accept_s) begin
      pc_d = seq_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= {ADDR_W{1'b0}};
`ifdef DELAY_SLOT_EN
      pend_wait_q <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      addr_err_q  <= addr_err_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
`ifdef DELAY_SLOT_EN
      pend_wait_q <= pend_wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit (default parameters).
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic        stall;
  logic [31:0] ctl_pc;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        branch_en;
  logic [15:0] branch_off;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        exc_en;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_ready(fetch_ready),
    .stall      (stall),
    .ctl_pc     (ctl_pc),
    .jump_en    (jump_en),
    .jump_index (jump_index),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .jr_en      (jr_en),
    .jr_addr    (jr_addr),
    .exc_en     (exc_en),
    .pc_out     (pc_out),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    jump_en   = 1'b0;
    branch_en = 1'b0;
    jr_en     = 1'b0;
    exc_en    = 1'b0;
  endtask

  // Compare all four outputs in one go.
  task automatic expect_out(input string tag, input logic [31:0] pc, input logic v,
                            input logic f, input logic ae);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, v});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, ae});
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_ready = 1'b1;
    stall       = 1'b0;
    ctl_pc      = 32'h0;
    jump_index  = 26'h0;
    branch_off  = 16'h0;
    jr_addr     = 32'h0;
    clear_req();

    // Reset state
    #12;
    expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); expect_out("first_valid", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check("seq4", pc_out, 32'h4);
    tick(); check("seq8", pc_out, 32'h8);
    tick(); check("seqC", pc_out, 32'hC);

`ifndef DELAY_SLOT_EN
    // Jump with upper bits taken from ctl_pc+4
    ctl_pc = 32'h4000_0010; jump_index = 26'h0000100; jump_en = 1'b1;
    tick(); expect_out("jump", 32'h4000_0400, 1'b1, 1'b1, 1'b0);
    clear_req();
    tick(); expect_out("jump_after", 32'h4000_0404, 1'b1, 1'b0, 1'b0);

    // Jump beats branch in the same cycle
    ctl_pc = 32'h100; jump_index = 26'h40; branch_off = 16'hFFFC;
    jump_en = 1'b1; branch_en = 1'b1;
    tick(); expect_out("prio_jump", 32'h100, 1'b1, 1'b1, 1'b0);
    clear_req();
    branch_en = 1'b1;
    tick(); expect_out("branch_neg", 32'hF4, 1'b1, 1'b1, 1'b0);
    clear_req();
    tick(); expect_out("branch_after", 32'hF8, 1'b1, 1'b0, 1'b0);

    // Pending redirect while fetch not ready; second redirect ignored
    jr_addr = 32'h20; jr_en = 1'b1;
    tick(); check("to_20", pc_out, 32'h20);
    clear_req();
    fetch_ready = 1'b0;
    jr_addr = 32'h300; jr_en = 1'b1;
    tick(); expect_out("pend_hold", 32'h20, 1'b1, 1'b0, 1'b0);
    clear_req();
    ctl_pc = 32'h100; branch_off = 16'hFFFC; branch_en = 1'b1;
    tick(); expect_out("pend_ignore", 32'h20, 1'b1, 1'b0, 1'b0);
    clear_req();
    fetch_ready = 1'b1;
    tick(); expect_out("pend_apply", 32'h300, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("pend_clear", 32'h304, 1'b1, 1'b0, 1'b0);

    // Stall holds the PC
    stall = 1'b1;
    tick(); check("stall_hold", pc_out, 32'h304);
    stall = 1'b0;

    // Address wrap
    jr_addr = 32'hFFFF_FFFC; jr_en = 1'b1;
    tick(); check("to_top", pc_out, 32'hFFFF_FFFC);
    clear_req();
    tick(); expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
`else
    // Delay slot: fetch 0x10 then 0x14, then the jump target, no flush
    tick(); check("ds_at_10", pc_out, 32'h10);
    ctl_pc = 32'h10; jump_index = 26'h40; jump_en = 1'b1;
    tick(); expect_out("ds_slot", 32'h14, 1'b1, 1'b0, 1'b0);
    clear_req();
    tick(); expect_out("ds_target", 32'h100, 1'b1, 1'b0, 1'b0);
    tick(); check("ds_after", pc_out, 32'h104);
`endif

    // Misaligned jr: exception even with fetch not ready
    fetch_ready = 1'b0;
    jr_addr = 32'h302; jr_en = 1'b1;
    tick(); expect_out("misalign", 32'h80, 1'b1, 1'b1, 1'b1);
    clear_req();
    tick(); expect_out("misalign_after", 32'h80, 1'b1, 1'b0, 1'b0);
    fetch_ready = 1'b1;
    tick(); check("exc_seq", pc_out, 32'h84);

    // exc_en beats an aligned jr; no addr_err
    exc_en = 1'b1; jr_addr = 32'h300; jr_en = 1'b1;
    tick(); expect_out("exc_prio", 32'h80, 1'b1, 1'b1, 1'b0);
    clear_req();

    // Exception discards a pending redirect
    fetch_ready = 1'b0;
    ctl_pc = 32'h4000_0010; jump_index = 26'h100; jump_en = 1'b1;
    tick(); check("pend2_hold", pc_out, 32'h80);
    clear_req();
    exc_en = 1'b1;
    tick(); expect_out("exc_clr_pend", 32'h80, 1'b1, 1'b1, 1'b0);
    clear_req();
    fetch_ready = 1'b1;
    tick(); expect_out("no_stale_pend", 32'h84, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation discards a pending redirect
    fetch_ready = 1'b0;
    jr_addr = 32'h300; jr_en = 1'b1;
    tick();
    clear_req();
    rst_n = 1'b0;
    #1;
    expect_out("reset_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    tick(); check("rst2_pc0", pc_out, 32'h0);
    tick(); expect_out("rst2_seq", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised program-counter unit: generalises the fixed jump-target concatenation into a registered PC with jump, branch, register-jump and exception redirects.
- Sits between decode/execute and instruction memory.
- Presents the fetch address with a valid/ready handshake and holds a single pending redirect while fetch is stalled.

Parameters:
ADDR_W, 32, PC/address width; must satisfy ADDR_W > IDX_W + ALIGN
IDX_W, 26, jump index field width
ALIGN, 2, log2 instruction size; sequential step = 1<<ALIGN
OFF_W, 16, branch offset width, signed
RESET_PC, 32'h0000_0000, PC value after reset
EXC_VEC, 32'h0000_0080, exception/address-error target

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_ready  in  1  imem accepts pc_out this cycle
stall  in  1  pipeline stall; blocks sequential advance
ctl_pc  in  ADDR_W  PC of the control instruction raising a redirect
jump_en  in  1  J-type redirect request
jump_index  in  IDX_W  J-type index field
branch_en  in  1  taken-branch redirect request
branch_off  in  OFF_W  signed word offset
jr_en  in  1  register-jump redirect request
jr_addr  in  ADDR_W  register-jump target
exc_en  in  1  exception request
pc_out  out  ADDR_W  current fetch address
pc_valid  out  1  pc_out is a valid fetch request
flush  out  1  one-cycle pulse: discard in-flight fetched instruction
addr_err  out  1  one-cycle pulse: misaligned jr_addr

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC, pc_valid=0, flush=0, addr_err=0, pending cleared.
  - pc_valid goes 1 on the first rising edge after rst_n deasserts.
- Reset mid-operation discards any pending redirect.
- Handshake:
  - Fetch accepted on an edge with pc_valid && fetch_ready && !stall.
  - pc_out is stable while pc_valid=1 and not accepted, except on exception.
- Target arithmetic (all modulo 2^ADDR_W, wrap silently):
  - seq = pc_out + (1<<ALIGN)
  - ctl4 = ctl_pc + (1<<ALIGN)
  - jump target = {ctl4[ADDR_W-1:IDX_W+ALIGN], jump_index, ALIGN'b0}
  - branch target = ctl4 + (sign_ext(branch_off) << ALIGN)
  - jr target = jr_addr
- Same-cycle priority: exc_en > jr_en > jump_en > branch_en; only the winner is used.
- Misaligned jr: jr_en with jr_addr[ALIGN-1:0] != 0 → addr_err pulse next cycle; treated as exception to EXC_VEC.
- Exception (or misaligned jr):
  - Immediate: at next edge pc_out=EXC_VEC, flush=1 for one cycle, pending cleared.
  - Ignores the handshake hold.
- Non-exception redirect, no pending:
  - If accepted this edge, pc_out=target at that edge and flush=1.
  - Otherwise captured into pending; pc_out unchanged.
- Pending applied on the next accepted edge instead of seq; flush=1 that cycle; pending clears.
- While pending is held, new non-exception redirects are ignored (wrong path).
- Sequential: on an accepted edge with no redirect/pending, pc_out=seq.
- stall=1 with no exception: pc_out held, pending retained.
- Latency: redirect request to pc_out change is 1 edge when accepted; otherwise the first accepted edge.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined: non-exception redirects are deferred by exactly one accepted fetch (the delay slot at ctl4 is fetched); target applied on the following accepted edge; flush not asserted for branch/jump/jr. Exceptions unchanged (immediate, flush=1).
- Undefined: behaviour as above, no delay slot, flush asserted on every redirect apply.

Test Plan:
- Reset: rst_n=0 then 1, fetch_ready=1 → pc_out=0, pc_valid=0 then 1; pc_out 0,4,8,C on successive edges.
- Jump: ctl_pc=32'h4000_0010, jump_index=26'h0000100, fetch_ready=1 → pc_out=32'h4000_0400, flush pulse one cycle.
- Branch negative + priority: ctl_pc=32'h100, branch_off=-4, same cycle jump_en=1, index=26'h40 → jump wins, pc_out=32'h100; rerun with branch only → pc_out=32'hF4.
- Pending: fetch_ready=0 at pc_out=32'h20, jr_en with jr_addr=32'h300 → pc_out held at 32'h20; second branch_en ignored; fetch_ready=1 → pc_out=32'h300.
- Exception/misaligned: jr_addr=32'h302 → addr_err pulse, pc_out=32'h80, flush=1, even with fetch_ready=0.
- Wrap/delay slot: pc_out=32'hFFFF_FFFC accepted → 32'h0; with DELAY_SLOT_EN, jump at ctl_pc=32'h10 → next pc_out=32'h14, then target, flush=0.
